// File: rtl/btn_feeder_pkg.sv
// btn_feeder_pkg: debounce state encoding, default parameters and counter-width helper
package btn_feeder_pkg;
  typedef enum logic [1:0] {
    ST_LO  = 2'd0,
    ARM_HI = 2'd1,
    ST_HI  = 2'd2,
    ARM_LO = 2'd3
  } deb_state_t;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_TICK_DIV        = 67_108_864;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: 2-FF synchroniser plus 4-state debounce FSM for a raw button
// Ports: clk, rst_n (async active-low), btn (raw level) -> sdi (debounced level),
//        press (one-cycle pulse on debounced rise)
module sync_debounce
  import btn_feeder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic sdi,
  output logic press
);
  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync;
  logic s;
  deb_state_t state, state_nxt;
  logic [DW-1:0] deb_cnt, deb_cnt_nxt;
  assign s = sync[1];
  // sdi and press are registered from the settled state, so a glitch that
  // aborts an ARM_* state back to its stable state never reaches the outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      state   <= ST_LO;
      deb_cnt <= '0;
      sdi     <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync    <= {sync[0], btn};
      state   <= state_nxt;
      deb_cnt <= deb_cnt_nxt;
      sdi     <= state == ST_HI || state == ARM_LO;
      press   <= state == ST_HI && !sdi;
    end
  end
  always_comb begin
    state_nxt   = state;
    deb_cnt_nxt = deb_cnt;
    case (state)
      ST_LO: if (s) begin
        state_nxt   = ARM_HI;
        deb_cnt_nxt = '0;
      end
      ARM_HI: if (!s) state_nxt = ST_LO;
        else if (deb_cnt == DEB_LAST) state_nxt = ST_HI;
        else deb_cnt_nxt = deb_cnt + DW'(1);
      ST_HI: if (!s) begin
        state_nxt   = ARM_LO;
        deb_cnt_nxt = '0;
      end
      ARM_LO: if (s) state_nxt = ST_HI;
        else if (deb_cnt == DEB_LAST) state_nxt = ST_LO;
        else deb_cnt_nxt = deb_cnt + DW'(1);
      default: state_nxt = ST_LO;
    endcase
  end
endmodule

// File: rtl/btn_serial_feeder.sv
// btn_serial_feeder: debounced serial data bit plus periodic shift strobe for a SIPO register
// Ports: clk, rst_n (async active-low), btn (raw level) -> sdi (debounced data),
//        shift_en (one cycle every TICK_DIV clocks), press (debounced rise pulse)
module btn_serial_feeder
  import btn_feeder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TICK_DIV        = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic sdi,
  output logic shift_en,
  output logic press
);
  localparam int TW = cnt_w(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  logic [TW-1:0] tick_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      shift_en <= 1'b0;
    end else begin
      tick_cnt <= tick_cnt == TICK_LAST ? '0 : tick_cnt + TW'(1);
      shift_en <= tick_cnt == TICK_LAST;
    end
  end
  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn),
    .sdi  (sdi),
    .press(press)
  );
endmodule
